// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared offsets and base address for the MMIO performance counters
package counter_pkg;

    localparam logic [31:0] CNT_BASE_ADDR      = 32'h8000_0010;

    // Byte offsets of each word inside the counter window
    localparam logic [4:0]  CNT_CYCLE_LO_OFF   = 5'h00;
    localparam logic [4:0]  CNT_CYCLE_HI_OFF   = 5'h04;
    localparam logic [4:0]  CNT_CLR_OFF        = 5'h08;
    localparam logic [4:0]  CNT_INSTRET_LO_OFF = 5'h0C;
    localparam logic [4:0]  CNT_INSTRET_HI_OFF = 5'h10;

    // Window spans +0x00..+0x13
    localparam logic [31:0] CNT_WINDOW_BYTES   = 32'h14;

endpackage

// File: rtl/cnt_wide.sv
// rtl/cnt_wide.sv - wide free-running counter with synchronous clear and enable
module cnt_wide
    import counter_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear beats increment, wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mmio_counter_reader.sv
// rtl/mmio_counter_reader.sv - MMIO cycle/instret counter load responder (option: COUNTER_SNAPSHOT_EN)
module mmio_counter_reader
    import counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = CNT_BASE_ADDR,
    parameter int          CNT_W     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic [31:0] addr,
    input  logic [3:0]  wbe,
    input  logic        instr_retired,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        hit
);

    logic [31:0]      word_addr;
    logic [31:0]      off;
    logic [4:0]       off_w;
    logic             clr;
    logic             rd_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
    logic [63:0]      cycle_64;
    logic [63:0]      instret_64;
    logic [31:0]      cycle_hi_rd;
    logic [31:0]      instret_hi_rd;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             rvalid_q;
    logic             rvalid_d;

    // Byte lanes are ignored; addresses below the base wrap high and miss
    assign word_addr = {addr[31:2], 2'b00};
    assign off       = word_addr - BASE_ADDR;
    assign off_w     = off[4:0];
    assign hit       = (off < CNT_WINDOW_BYTES);
    assign clr       = (wbe != 4'h0) && hit && (off_w == CNT_CLR_OFF);
    assign rd_en     = ren && hit;

    cnt_wide #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (1'b1),
        .cnt (cycle_cnt)
    );

    cnt_wide #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (instr_retired),
        .cnt (instret_cnt)
    );

    // Bits above CNT_W-1 read as zero
    assign cycle_64   = 64'(cycle_cnt);
    assign instret_64 = 64'(instret_cnt);

`ifdef COUNTER_SNAPSHOT_EN
    logic [31:0] cycle_hi_q;
    logic [31:0] cycle_hi_d;
    logic [31:0] instret_hi_q;
    logic [31:0] instret_hi_d;

    // Low-word loads capture the matching high half so a lo/hi pair is coherent
    always_comb begin
        cycle_hi_d   = cycle_hi_q;
        instret_hi_d = instret_hi_q;
        if (clr) begin
            cycle_hi_d   = '0;
            instret_hi_d = '0;
        end else if (rd_en) begin
            if (off_w == CNT_CYCLE_LO_OFF)   cycle_hi_d   = cycle_64[63:32];
            if (off_w == CNT_INSTRET_LO_OFF) instret_hi_d = instret_64[63:32];
        end
    end

    // Shadow registers for the high halves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_hi_q   <= '0;
            instret_hi_q <= '0;
        end else begin
            cycle_hi_q   <= cycle_hi_d;
            instret_hi_q <= instret_hi_d;
        end
    end

    assign cycle_hi_rd   = cycle_hi_q;
    assign instret_hi_rd = instret_hi_q;
`else
    assign cycle_hi_rd   = cycle_64[63:32];
    assign instret_hi_rd = instret_64[63:32];
`endif

    // Read mux: selects from pre-edge counter values; misses hold rdata
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_en;
        if (rd_en) begin
            case (off_w)
                CNT_CYCLE_LO_OFF:   rdata_d = cycle_64[31:0];
                CNT_CYCLE_HI_OFF:   rdata_d = cycle_hi_rd;
                CNT_INSTRET_LO_OFF: rdata_d = instret_64[31:0];
                CNT_INSTRET_HI_OFF: rdata_d = instret_hi_rd;
                default:            rdata_d = '0;
            endcase
        end
    end

    // Registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_mmio_counter_reader.sv
// tb/tb_mmio_counter_reader.sv - scoreboard testbench for mmio_counter_reader
module tb_mmio_counter_reader;

    localparam logic [31:0] BASE = 32'h8000_0010;

    logic        clk;
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic [3:0]  wbe;
    logic        instr_retired;
    logic [31:0] rdata;
    logic        rvalid;
    logic        hit;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    logic [63:0] m_cyc;
    logic [63:0] m_ins;
    logic [31:0] m_csh;
    logic [31:0] m_ish;
    logic [31:0] last_exp;

    mmio_counter_reader #(.BASE_ADDR(BASE), .CNT_W(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .ren           (ren),
        .addr          (addr),
        .wbe           (wbe),
        .instr_retired (instr_retired),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .hit           (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of the counters
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = '0;
            m_ins = '0;
            m_csh = '0;
            m_ish = '0;
        end else if (wbe != 4'h0 && ({addr[31:2], 2'b00} == BASE + 32'h8)) begin
            m_cyc = '0;
            m_ins = '0;
            m_csh = '0;
            m_ish = '0;
        end else begin
            m_cyc = m_cyc + 64'd1;
            if (instr_retired) m_ins = m_ins + 64'd1;
        end
    end

    // Response monitor: pops expected words when they fall due
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data) begin
                errors++;
                $display("FAIL rsp cyc=%0d got rvalid=%b rdata=%h want rvalid=1 rdata=%h",
                         cyc, rvalid, rdata, e.data);
            end
        end else if (!rst) begin
            checks++;
            if (rvalid !== 1'b0) begin
                errors++;
                $display("FAIL idle cyc=%0d got rvalid=%b want 0", cyc, rvalid);
            end
        end
    end

    function automatic logic [31:0] model_word(input logic [4:0] o);
        case (o)
            5'h00: return m_cyc[31:0];
`ifdef COUNTER_SNAPSHOT_EN
            5'h04: return m_csh;
            5'h10: return m_ish;
`else
            5'h04: return m_cyc[63:32];
            5'h10: return m_ins[63:32];
`endif
            5'h0C: return m_ins[31:0];
            default: return 32'h0;
        endcase
    endfunction

    // Issue one load at a drive point; returns one cycle later with rdata valid
    task automatic load(input logic [31:0] a);
        exp_t        e;
        logic [31:0] o;
        o      = {a[31:2], 2'b00} - BASE;
        e.due  = cyc + 1;
        e.data = model_word(o[4:0]);
        sb.push_back(e);
        last_exp = e.data;
        if (o[4:0] == 5'h00) m_csh = m_cyc[63:32];
        if (o[4:0] == 5'h0C) m_ish = m_ins[63:32];
        ren  = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        ren = 1'b0;
    endtask

    task automatic retire_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            instr_retired = 1'b1;
            @(posedge clk);
            #1;
            instr_retired = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] hit_addr [4];
        logic        hit_exp  [4];
        hit_addr = '{BASE, BASE + 32'h13, BASE + 32'h14, BASE - 32'h1};
        hit_exp  = '{1'b1, 1'b1, 1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got rvalid=%b rdata=%h want 0/0", rvalid, rdata);
        end
        for (int i = 0; i < 4; i++) begin
            addr = hit_addr[i];
            #1;
            checks++;
            if (hit !== hit_exp[i]) begin
                errors++;
                $display("FAIL hit addr=%h got %b want %b", hit_addr[i], hit, hit_exp[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        load(BASE);
        checks++;
        if (rdata !== 32'd10) begin
            errors++;
            $display("FAIL first_cycle got %0d want 10", rdata);
        end
        load(BASE + 32'h4);
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL first_cycle_hi got %h want 0", rdata);
        end
    endtask

    task automatic test_clear;
        retire_pulses(3);
        wbe           = 4'hF;
        addr          = BASE + 32'h8;
        instr_retired = 1'b1;
        @(posedge clk);
        #1;
        wbe           = 4'h0;
        instr_retired = 1'b0;
        load(BASE);
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL clear_cycle got %0d want 0", rdata);
        end
        load(BASE + 32'hC);
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL clear_instret got %0d want 0", rdata);
        end
    endtask

    task automatic test_instret;
        retire_pulses(5);
        load(BASE + 32'hC);
        checks++;
        if (rdata !== 32'd5) begin
            errors++;
            $display("FAIL instret got %0d want 5", rdata);
        end
        load(BASE + 32'h8);
        checks++;
        if (rdata !== 32'd0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL clr_read got rdata=%h rvalid=%b want 0/1", rdata, rvalid);
        end
        // Store to a non-clear offset must not disturb the counters
        wbe  = 4'h1;
        addr = BASE + 32'hC;
        @(posedge clk);
        #1;
        wbe = 4'h0;
        load(BASE + 32'hC);
        checks++;
        if (rdata !== 32'd5) begin
            errors++;
            $display("FAIL store_ignored got %0d want 5", rdata);
        end
    endtask

    task automatic test_carry;
        dut.u_cycle_cnt.cnt_q = 64'h0000_0000_FFFF_FFFF;
        m_cyc = 64'h0000_0000_FFFF_FFFF;
        load(BASE);
        checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL carry_lo got %h want ffffffff", rdata);
        end
        load(BASE + 32'h4);
        checks++;
`ifdef COUNTER_SNAPSHOT_EN
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL carry_hi got %h want 0", rdata);
        end
`else
        if (rdata !== 32'h1) begin
            errors++;
            $display("FAIL carry_hi got %h want 1", rdata);
        end
`endif
    endtask

    task automatic test_wrap;
        dut.u_cycle_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        load(BASE);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL wrap_lo got %h want 0", rdata);
        end
        load(BASE + 32'h4);
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL wrap_hi got %h want 0", rdata);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] seq [6];
        seq = '{BASE, BASE, BASE + 32'hD, BASE + 32'h10, BASE + 32'h3, BASE + 32'h4};
        instr_retired = 1'b1;
        for (int i = 0; i < 6; i++) load(seq[i]);
        instr_retired = 1'b0;
    endtask

    task automatic test_miss;
        logic [31:0] miss [2];
        miss = '{BASE + 32'h14, BASE - 32'h4};
        for (int i = 0; i < 2; i++) begin
            ren  = 1'b1;
            addr = miss[i];
            @(posedge clk);
            #1;
            ren = 1'b0;
            checks++;
            if (rvalid !== 1'b0 || rdata !== last_exp) begin
                errors++;
                $display("FAIL miss addr=%h got rvalid=%b rdata=%h want 0/%h",
                         miss[i], rvalid, rdata, last_exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        ren  = 1'b1;
        addr = BASE;
        @(posedge clk);
        #1;
        ren = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_rvalid got %b want 1", rvalid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_rst got rvalid=%b rdata=%h want 0/0", rvalid, rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        load(BASE);
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL restart0 got %0d want 0", rdata);
        end
        load(BASE);
        checks++;
        if (rdata !== 32'd1) begin
            errors++;
            $display("FAIL restart1 got %0d want 1", rdata);
        end
    endtask

    initial begin
        rst           = 1'b1;
        ren           = 1'b0;
        addr          = '0;
        wbe           = 4'h0;
        instr_retired = 1'b0;
        last_exp      = '0;
        test_reset;
        test_clear;
        test_instret;
        test_carry;
        test_wrap;
        test_back_to_back;
        test_miss;
        test_reset_mid;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
